// File: rtl/ahb_master_resp_mux.sv
// ahb_master_resp_mux
//   Data-phase return path for one AHB master. The decoder's slave select is
//   registered at every accepted address phase (hready=1). That registered
//   select then steers the chosen slave's hrdata/hreadyout/hresp back to the
//   master without adding any latency. Unmapped accesses go to a built-in
//   default slave, which returns a two-cycle ERROR response.
// Ports
//   hclk, hreset_n      clock, async active-low reset
//   htrans              master transfer type (address phase)
//   hreq                decoder one-hot slave select (address phase)
//   default_slv_sel     decoder: access targets an unmapped region
//   hrdata_s/hreadyout_s/hresp_s  per-slave data-phase responses
//   hrdata/hready/hresp response to master (hready also goes back to slaves)
//   sel_conflict        pulse: more than one hreq bit set at an accepted phase
//   err_cnt             saturating count of default-slave ERROR responses
module ahb_master_resp_mux #(
  parameter int MASTER_X_SLAVE_NUM = 4,
  parameter int AHB_DATA_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH      = 8
) (
  input  logic                                             hclk,
  input  logic                                             hreset_n,
  input  logic [1:0]                                       htrans,
  input  logic [MASTER_X_SLAVE_NUM-1:0]                    hreq,
  input  logic                                             default_slv_sel,
  input  logic [MASTER_X_SLAVE_NUM-1:0][AHB_DATA_WIDTH-1:0] hrdata_s,
  input  logic [MASTER_X_SLAVE_NUM-1:0]                    hreadyout_s,
  input  logic [MASTER_X_SLAVE_NUM-1:0][1:0]               hresp_s,
  output logic [AHB_DATA_WIDTH-1:0]                        hrdata,
  output logic                                             hready,
  output logic [1:0]                                       hresp,
  output logic                                             sel_conflict,
  output logic [ERR_CNT_WIDTH-1:0]                         err_cnt
);

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_ERROR    = 2'b01;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

  ds_state_e                     ds_state_q, ds_state_d;
  logic [MASTER_X_SLAVE_NUM-1:0] dsel_q, dsel_d;
  logic                          conflict_q, conflict_d;
  logic [ERR_CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;

  logic [AHB_DATA_WIDTH-1:0]     mux_rdata;
  logic                          mux_ready;
  logic [1:0]                    mux_resp;
  logic                          mux_found;
  logic                          err_hit;

  // Slave mux. The lowest set select bit wins, so a conflicting select still
  // produces a single well-defined response.
  always_comb begin
    mux_rdata = '0;
    mux_ready = 1'b1;
    mux_resp  = RESP_OKAY;
    mux_found = 1'b0;
    for (int i = 0; i < MASTER_X_SLAVE_NUM; i++) begin
      if (dsel_q[i] && !mux_found) begin
        mux_rdata = hrdata_s[i];
        mux_ready = hreadyout_s[i];
        mux_resp  = hresp_s[i];
        mux_found = 1'b1;
      end
    end
  end

  // While the default slave is active, its response overrides the mux.
  // dsel_q is zero in that case because the unmapped phase captured hreq=0.
  always_comb begin
    hrdata = mux_rdata;
    hready = mux_ready;
    hresp  = mux_resp;
    case (ds_state_q)
      DS_ERR1: begin
        hrdata = '0;
        hready = 1'b0;
        hresp  = RESP_ERROR;
      end
      DS_ERR2: begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = RESP_ERROR;
      end
      default: ;
    endcase
  end

  // Only NONSEQ/SEQ to an unmapped region is an error. BUSY is not. A
  // real hreq also takes priority over default_slv_sel.
  assign err_hit = default_slv_sel && (hreq == '0) &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  always_comb begin
    dsel_d     = dsel_q;
    conflict_d = 1'b0;
    ds_state_d = ds_state_q;
    err_cnt_d  = err_cnt_q;
    if (hready) begin
      dsel_d     = hreq;
      conflict_d = ($countones(hreq) > 1);
    end
    case (ds_state_q)
      DS_IDLE: if (hready && err_hit) ds_state_d = DS_ERR1;
      DS_ERR1: ds_state_d = DS_ERR2;
      DS_ERR2: begin
        // hready is 1 here, so the next address phase is accepted now.
        ds_state_d = err_hit ? DS_ERR1 : DS_IDLE;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
      default: ds_state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      ds_state_q <= DS_IDLE;
      dsel_q     <= '0;
      conflict_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      ds_state_q <= ds_state_d;
      dsel_q     <= dsel_d;
      conflict_q <= conflict_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign sel_conflict = conflict_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ahb_master_resp_mux.sv
// Bench for ahb_master_resp_mux. The driver issues one address phase per
// accepted cycle and queues the expected data-phase result. The monitor
// counts wait cycles and checks each completed data phase (hready=1)
// against the head of the queue.
module tb_ahb_master_resp_mux;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = 8;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [1:0] OK = 2'b00, ER = 2'b01, RT = 2'b10;

  logic                  hclk = 1'b0;
  logic                  hreset_n = 1'b0;
  logic [1:0]            htrans = IDLE;
  logic [N-1:0]          hreq = '0;
  logic                  default_slv_sel = 1'b0;
  logic [N-1:0][DW-1:0]  hrdata_s;
  logic [N-1:0]          hreadyout_s;
  logic [N-1:0][1:0]     hresp_s;
  logic [DW-1:0]         hrdata;
  logic                  hready;
  logic [1:0]            hresp;
  logic                  sel_conflict;
  logic [EW-1:0]         err_cnt;

  ahb_master_resp_mux #(.MASTER_X_SLAVE_NUM(N), .AHB_DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .htrans(htrans), .hreq(hreq),
    .default_slv_sel(default_slv_sel), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
    .hresp_s(hresp_s), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .sel_conflict(sel_conflict), .err_cnt(err_cnt));

  always #5 hclk = ~hclk;

  // Slave model: each slave inserts wait_cfg[i] wait states after being selected.
  int wait_cfg [N];
  int cnt [N];
  always @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hready && hreq[i]) cnt[i] <= wait_cfg[i];
        else if (cnt[i] > 0)   cnt[i] <= cnt[i] - 1;
      end
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) hreadyout_s[i] = (cnt[i] == 0);
  end

  typedef struct {
    int          waits;
    logic [1:0]  wresp;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [7:0]  err;
    logic        conf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   mw = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge hclk) begin
    #2;
    if (!mon_en) begin
      mw = 0;
    end else if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: data phase observed with no expected entry at %0t", $time);
    end else if (!hready) begin
      mw++;
      chk("wait_resp", {30'd0, hresp}, {30'd0, q[0].wresp});
    end else begin
      e = q.pop_front();
      chk("waits",    32'(mw),               32'(e.waits));
      chk("hresp",    {30'd0, hresp},        {30'd0, e.resp});
      chk("hrdata",   hrdata,                e.data);
      chk("err_cnt",  {24'd0, err_cnt},      {24'd0, e.err});
      chk("conflict", {31'd0, sel_conflict}, {31'd0, e.conf});
      mw = 0;
    end
  end

  // Drive one address phase starting at a negedge, hold it until accepted,
  // queue the expected result of its data phase, and return at the next negedge.
  task automatic issue(input logic [1:0] tr, input logic [3:0] rq, input logic ds,
                       input int w, input logic [1:0] wr, input logic [1:0] r,
                       input logic [31:0] d, input logic [7:0] er, input logic cf);
    int n = 0;
    exp_t x;
    htrans = tr; hreq = rq; default_slv_sel = ds;
    #1;
    while (!hready && n < 20) begin
      @(negedge hclk); #1; n++;
    end
    if (!hready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: hready stuck low at %0t", $time);
    end
    x.waits = w; x.wresp = wr; x.resp = r; x.data = d; x.err = er; x.conf = cf;
    q.push_back(x);
    @(negedge hclk);
  endtask

  task automatic idle(input logic [7:0] er);
    issue(IDLE, 4'b0000, 1'b0, 0, OK, OK, 32'h0, er, 1'b0);
  endtask

  task automatic err_xfer(input logic [1:0] tr, input logic [7:0] er);
    issue(tr, 4'b0000, 1'b1, 1, ER, ER, 32'h0, er, 1'b0);
  endtask

  // Assert reset from a negedge and check the async reset values right away.
  // Release it two cycles later and queue the idle reset data phase.
  task automatic do_reset();
    exp_t x;
    hreset_n = 1'b0;
    mon_en = 1'b0;
    q.delete();
    htrans = IDLE; hreq = '0; default_slv_sel = 1'b0;
    #1;
    chk("rst_hready",   {31'd0, hready},       32'd1);
    chk("rst_hresp",    {30'd0, hresp},        32'd0);
    chk("rst_hrdata",   hrdata,                32'd0);
    chk("rst_err_cnt",  {24'd0, err_cnt},      32'd0);
    chk("rst_conflict", {31'd0, sel_conflict}, 32'd0);
    repeat (2) @(negedge hclk);
    hreset_n = 1'b1;
    x.waits = 0; x.wresp = OK; x.resp = OK; x.data = 32'h0; x.err = 8'd0; x.conf = 1'b0;
    q.push_back(x);
    mon_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      hrdata_s[i] = 32'hA5A5_0000 + 32'(i);
      wait_cfg[i] = 0;
    end
    hresp_s = {RT, OK, OK, OK};

    @(negedge hclk);
    do_reset();

    // 1: some traffic, then reset while slave1 is stalling.
    issue(NONSEQ, 4'b0001, 1'b0, 0, OK, OK, 32'hA5A5_0000, 8'd0, 1'b0);
    wait_cfg[1] = 3;
    issue(NONSEQ, 4'b0010, 1'b0, 3, OK, OK, 32'hA5A5_0001, 8'd0, 1'b0);
    do_reset();

    // 2: slave1 with two wait states. The IDLE driven during the stall
    //    must not disturb the held select.
    wait_cfg[1] = 2;
    issue(NONSEQ, 4'b0010, 1'b0, 2, OK, OK, 32'hA5A5_0001, 8'd0, 1'b0);
    idle(8'd0);

    // 3: one unmapped NONSEQ.
    err_xfer(NONSEQ, 8'd0);
    idle(8'd1);

    // 4: back-to-back unmapped accesses, then back to idle.
    err_xfer(NONSEQ, 8'd1);
    err_xfer(NONSEQ, 8'd2);
    idle(8'd3);

    // 5a: BUSY to an unmapped region completes with zero wait states and OKAY.
    issue(BUSY, 4'b0000, 1'b1, 0, OK, OK, 32'h0, 8'd3, 1'b0);
    idle(8'd3);

    // 6a: conflicting select. The lowest index (slave1) wins and a one-cycle pulse is raised.
    wait_cfg[1] = 0;
    issue(NONSEQ, 4'b0110, 1'b0, 0, OK, OK, 32'hA5A5_0001, 8'd3, 1'b1);
    idle(8'd3);

    // hreq takes priority over default_slv_sel; RETRY is passed through unchanged.
    issue(NONSEQ, 4'b0001, 1'b1, 0, OK, OK, 32'hA5A5_0000, 8'd3, 1'b0);
    issue(SEQ,    4'b1000, 1'b0, 0, RT, RT, 32'hA5A5_0003, 8'd3, 1'b0);

    // 5b: saturation. 255 errors in total, then the counter sticks at FF.
    for (int i = 3; i < 255; i++) err_xfer(i[0] ? SEQ : NONSEQ, 8'(i));
    err_xfer(NONSEQ, 8'hFF);
    err_xfer(SEQ, 8'hFF);
    idle(8'hFF);

    // 6b: reset while the default slave is in its first ERROR cycle.
    err_xfer(NONSEQ, 8'hFF);
    do_reset();
    issue(NONSEQ, 4'b0100, 1'b0, 0, OK, OK, 32'hA5A5_0002, 8'd0, 1'b0);
    idle(8'd0);
    idle(8'd0);

    mon_en = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
